// File: rtl/edge_box_overlay.sv
`default_nettype none
// ============================================================================
// Module   : edge_box_overlay
// Purpose  : Counts thresholded edge pixels per frame and draws the previous
//            frame's edge bounding box over the video. Optional macro
//            EDGE_BINARIZE_EN outputs binarised edges for non-box pixels.
// Revision : 1.0
// ============================================================================
module edge_box_overlay #(
  parameter int                    DATA_WIDTH  = 24,
  parameter int                    H_SIZE      = 1024,
  parameter int                    V_SIZE      = 768,
  parameter int                    EDGE_THRESH = 128,
  parameter int                    MIN_COUNT   = 16,
  parameter logic [DATA_WIDTH-1:0] BOX_COLOR   = 24'hFF0000
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  hs,
  input  logic                  vs,
  input  logic                  de,
  input  logic [DATA_WIDTH-1:0] vin_data,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] vout_data,
  output logic [19:0]           edge_count,
  output logic                  box_valid,
  output logic [10:0]           box_x0,
  output logic [10:0]           box_x1,
  output logic [10:0]           box_y0,
  output logic [10:0]           box_y1,
  output logic                  frame_done
);

  localparam logic [10:0] C_POS_MAX = 11'h7FF;
  localparam logic [19:0] C_CNT_MAX = 20'hFFFFF;
  localparam logic [31:0] C_H_LIM   = 32'(H_SIZE);
  localparam logic [31:0] C_V_LIM   = 32'(V_SIZE);
  localparam logic [31:0] C_THRESH  = 32'(EDGE_THRESH);
  localparam logic [31:0] C_MIN_CNT = 32'(MIN_COUNT);

  logic                  hs_q, vs_q, de_q;
  logic [10:0]           x_q, x_d, y_q, y_d;
  logic [19:0]           cnt_q, cnt_d;
  logic [10:0]           minx_q, minx_d, maxx_q, maxx_d;
  logic [10:0]           miny_q, miny_d, maxy_q, maxy_d;
  logic [19:0]           edge_count_q, edge_count_d;
  logic                  box_valid_q, box_valid_d;
  logic [10:0]           box_x0_q, box_x0_d, box_x1_q, box_x1_d;
  logic [10:0]           box_y0_q, box_y0_d, box_y1_q, box_y1_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] vout_q, vout_d;

  logic                  vs_rise, de_fall, in_window, edge_pix, on_box;
  logic [19:0]           base_cnt;
  logic [10:0]           base_minx, base_maxx, base_miny, base_maxy;
  logic [DATA_WIDTH-1:0] pass_pix;

  always_comb begin
    vs_rise = vs & ~vs_q;
    de_fall = de_q & ~de;

    x_d = de ? ((x_q == C_POS_MAX) ? x_q : x_q + 11'd1) : 11'd0;
    if (vs_rise)
      y_d = 11'd0;
    else if (de_fall && (y_q != C_POS_MAX))
      y_d = y_q + 11'd1;
    else
      y_d = y_q;

    in_window = ({21'd0, x_q} < C_H_LIM) && ({21'd0, y_q} < C_V_LIM);
    edge_pix  = de && in_window && ({24'd0, vin_data[7:0]} >= C_THRESH);

    // A pixel coinciding with vs_rise lands on the freshly reinitialised frame.
    if (vs_rise) begin
      base_cnt  = 20'd0;
      base_minx = C_POS_MAX;
      base_maxx = 11'd0;
      base_miny = C_POS_MAX;
      base_maxy = 11'd0;
    end else begin
      base_cnt  = cnt_q;
      base_minx = minx_q;
      base_maxx = maxx_q;
      base_miny = miny_q;
      base_maxy = maxy_q;
    end

    cnt_d  = base_cnt;
    minx_d = base_minx;
    maxx_d = base_maxx;
    miny_d = base_miny;
    maxy_d = base_maxy;
    if (edge_pix) begin
      cnt_d  = (base_cnt == C_CNT_MAX) ? base_cnt : base_cnt + 20'd1;
      minx_d = (x_q < base_minx) ? x_q : base_minx;
      maxx_d = (x_q > base_maxx) ? x_q : base_maxx;
      miny_d = (y_q < base_miny) ? y_q : base_miny;
      maxy_d = (y_q > base_maxy) ? y_q : base_maxy;
    end

    edge_count_d = vs_rise ? cnt_q  : edge_count_q;
    box_x0_d     = vs_rise ? minx_q : box_x0_q;
    box_x1_d     = vs_rise ? maxx_q : box_x1_q;
    box_y0_d     = vs_rise ? miny_q : box_y0_q;
    box_y1_d     = vs_rise ? maxy_q : box_y1_q;
    box_valid_d  = vs_rise ? ({12'd0, cnt_q} >= C_MIN_CNT) : box_valid_q;
    frame_done_d = vs_rise;

    on_box = box_valid_q && de &&
             ((((x_q == box_x0_q) || (x_q == box_x1_q)) &&
               (y_q >= box_y0_q) && (y_q <= box_y1_q)) ||
              (((y_q == box_y0_q) || (y_q == box_y1_q)) &&
               (x_q >= box_x0_q) && (x_q <= box_x1_q)));

`ifdef EDGE_BINARIZE_EN
    pass_pix = edge_pix ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
`else
    pass_pix = vin_data;
`endif

    if (!de)
      vout_d = '0;
    else if (on_box)
      vout_d = BOX_COLOR;
    else
      vout_d = pass_pix;
  end

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      minx_q       <= '0;
      maxx_q       <= '0;
      miny_q       <= '0;
      maxy_q       <= '0;
      edge_count_q <= '0;
      box_valid_q  <= 1'b0;
      box_x0_q     <= '0;
      box_x1_q     <= '0;
      box_y0_q     <= '0;
      box_y1_q     <= '0;
      frame_done_q <= 1'b0;
      vout_q       <= '0;
    end else begin
      hs_q         <= hs;
      vs_q         <= vs;
      de_q         <= de;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      minx_q       <= minx_d;
      maxx_q       <= maxx_d;
      miny_q       <= miny_d;
      maxy_q       <= maxy_d;
      edge_count_q <= edge_count_d;
      box_valid_q  <= box_valid_d;
      box_x0_q     <= box_x0_d;
      box_x1_q     <= box_x1_d;
      box_y0_q     <= box_y0_d;
      box_y1_q     <= box_y1_d;
      frame_done_q <= frame_done_d;
      vout_q       <= vout_d;
    end
  end

  // The vs edge-detect and de-fall registers double as the 1-cycle delayed syncs.
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign de_o       = de_q;
  assign vout_data  = vout_q;
  assign edge_count = edge_count_q;
  assign box_valid  = box_valid_q;
  assign box_x0     = box_x0_q;
  assign box_x1     = box_x1_q;
  assign box_y0     = box_y0_q;
  assign box_y1     = box_y1_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_box_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_box_overlay
// Purpose  : Self-checking bench for edge_box_overlay on a 16x8 window.
// Revision : 1.0
// ============================================================================
module tb_edge_box_overlay;
  localparam int          DW  = 24;
  localparam int          HSZ = 16;
  localparam int          VSZ = 8;
  localparam int          TH  = 128;
  localparam int          MC  = 2;
  localparam logic [23:0] BOX = 24'hFF0000;

  logic          video_clk = 1'b0;
  logic          rst_n = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [DW-1:0] vin_data = '0;
  logic          hs_o, vs_o, de_o, box_valid, frame_done;
  logic [DW-1:0] vout_data;
  logic [19:0]   edge_count;
  logic [10:0]   box_x0, box_x1, box_y0, box_y1;

  always #5 video_clk = ~video_clk;

  edge_box_overlay #(
    .DATA_WIDTH(DW), .H_SIZE(HSZ), .V_SIZE(VSZ),
    .EDGE_THRESH(TH), .MIN_COUNT(MC), .BOX_COLOR(BOX)
  ) dut (
    .video_clk(video_clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de),
    .vin_data(vin_data), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
    .vout_data(vout_data), .edge_count(edge_count), .box_valid(box_valid),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fd;
    logic [23:0] vout;
  } exp_t;

  typedef struct {
    int         n_lines;
    int         len;
    int         mode;
    logic [7:0] fill;
    int         p0x, p0y, p1x, p1y;
    int         cnt;
    bit         valid;
    int         x0, y0, x1, y1;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   checks = 0, errors = 0, fd_seen = 0;
  bit   m_valid = 0, m_vs_prev = 0;
  int   m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit on_box(input int x, input int y);
    if (!m_valid) return 1'b0;
    return (((x == m_x0) || (x == m_x1)) && (y >= m_y0) && (y <= m_y1)) ||
           (((y == m_y0) || (y == m_y1)) && (x >= m_x0) && (x <= m_x1));
  endfunction

  function automatic logic [23:0] pass_pix(input logic [23:0] px, input int x, input int y);
`ifdef EDGE_BINARIZE_EN
    return (x < HSZ && y < VSZ && px[7:0] >= 8'(TH)) ? 24'hFFFFFF : 24'h0;
`else
    if (x < 0 || y < 0) return 24'h0;
    return px;
`endif
  endfunction

  function automatic logic [7:0] luma(input int mode, input logic [7:0] fill, input int x, input int y,
                                      input int p0x, input int p0y, input int p1x, input int p1y);
    case (mode)
      0:       return ((x == p0x && y == p0y) || (x == p1x && y == p1y)) ? 8'hFF : fill;
      1:       return (y != 0) ? 8'h00 : (x < 5) ? 8'h80 : (x < 10) ? 8'h7F : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  // One pixel clock: check the output of the previous cycle, then drive and predict.
  task automatic cycle(input logic r, input logic h, input logic v, input logic d,
                       input logic [23:0] px, input int x, input int y);
    exp_t e;
    exp_t a;
    @(negedge video_clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {hs_o, vs_o, de_o, frame_done, vout_data};
      if (frame_done === 1'b1) fd_seen++;
      check("stream{hs,vs,de,fd,vout}", 32'(a), 32'(e));
    end
    rst_n = r; hs = h; vs = v; de = d; vin_data = px;
    e = '0;
    if (!r) begin
      m_vs_prev = 1'b0;
      m_valid   = 1'b0;
    end else begin
      e.hs = h;
      e.vs = v;
      e.de = d;
      e.fd = v & ~m_vs_prev;
      m_vs_prev = v;
      if (d) e.vout = on_box(x, y) ? BOX : pass_pix(px, x, y);
    end
    sb_q.push_back(e);
  endtask

  task automatic blank_line(input int y);
    for (int b = 0; b < 4; b++) cycle(1'b1, b < 2, 1'b0, 1'b0, 24'h0, 0, y);
  endtask

  task automatic drive_frame(input vec_t v);
    logic [7:0] l;
    for (int y = 0; y < v.n_lines; y++) begin
      for (int x = 0; x < v.len; x++) begin
        l = luma(v.mode, v.fill, x, y, v.p0x, v.p0y, v.p1x, v.p1y);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, {l, l, l}, x, y);
      end
      blank_line(y);
    end
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, (i == 3 || i == 4), 1'b0, 24'h0, 0, 0);
  endtask

  task automatic check_stats(input string tag, input int cnt, input bit valid,
                             input int x0, input int y0, input int x1, input int y1);
    check({tag, ".edge_count"}, 32'(edge_count), 32'(cnt));
    check({tag, ".box_valid"},  32'(box_valid),  32'(valid));
    check({tag, ".box_x0"},     32'(box_x0),     32'(x0));
    check({tag, ".box_y0"},     32'(box_y0),     32'(y0));
    check({tag, ".box_x1"},     32'(box_x1),     32'(x1));
    check({tag, ".box_y1"},     32'(box_y1),     32'(y1));
    m_valid = valid;
    m_x0 = x0; m_y0 = y0; m_x1 = x1; m_y1 = y1;
  endtask

  initial begin
    int fd_before;
    vec_t mid;
    vecs[0] = '{8, 16, 0, 8'h00, 3, 2, 10, 5, 2, 1'b1, 3, 2, 10, 5};
    vecs[1] = '{8, 16, 0, 8'h10, -1, -1, -1, -1, 0, 1'b0, 2047, 2047, 0, 0};
    vecs[2] = '{8, 16, 1, 8'h00, -1, -1, -1, -1, 5, 1'b1, 0, 0, 4, 0};
    vecs[3] = '{8, 16, 0, 8'h00, 6, 3, -1, -1, 1, 1'b0, 6, 3, 6, 3};
    vecs[4] = '{10, 20, 2, 8'h00, -1, -1, -1, -1, 128, 1'b1, 0, 0, 15, 7};

    // Reset held for 3 cycles with de toggling.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, i[0], 24'hABCDEF, i, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    check("reset.frame_done_pulses", 32'(fd_seen), 32'd0);
    check_stats("reset", 0, 1'b0, 0, 0, 0, 0);

    // Leading frame start reinitialises the accumulators.
    fd_before = fd_seen;
    vs_pulse();
    check("start.frame_done_pulses", 32'(fd_seen - fd_before), 32'd1);
    check_stats("start", 0, 1'b0, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) begin
      fd_before = fd_seen;
      drive_frame(vecs[k]);
      vs_pulse();
      check($sformatf("vec%0d.frame_done_pulses", k), 32'(fd_seen - fd_before), 32'd1);
      check_stats($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].valid,
                  vecs[k].x0, vecs[k].y0, vecs[k].x1, vecs[k].y1);
    end

    // Reset in the middle of a box-drawing frame.
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 16; x++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h101010, x, y);
      blank_line(y);
    end
    for (int x = 0; x < 5; x++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h101010, x, 3);
    for (int x = 5; x < 7; x++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h101010, x, 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h202020, 7, 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h101010, 8, 3);
    check("midreset.box_valid", 32'(box_valid), 32'd0);
    check("midreset.edge_count", 32'(edge_count), 32'd0);
    for (int x = 9; x < 16; x++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h101010, x, 3);
    blank_line(3);
    for (int y = 4; y < 8; y++) begin
      for (int x = 0; x < 16; x++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'h101010, x, y);
      blank_line(y);
    end
    vs_pulse();
    check_stats("post_reset", 0, 1'b0, 0, 0, 0, 0);

    // A full frame after that still shows no overlay.
    mid = vecs[1];
    drive_frame(mid);
    vs_pulse();
    check_stats("final", 0, 1'b0, 2047, 2047, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_box_overlay.md
Name: edge_box_overlay

Overview:
- Sits directly downstream of the Sobel edge stage in the HDMI output path. Consumes its delayed hs/vs/de and grey-replicated edge video.
- Thresholds edge pixels and counts them per frame. Tracks the bounding box of edge activity.
- During the following frame, draws that box as a 1-pixel rectangle over the video.
- Exports per-frame statistics to the control/debug logic.

Parameters:
- DATA_WIDTH, 24, pixel width (RGB888); luma taken from bits [7:0].
- H_SIZE, 1024, active pixels per line; pixels with x >= H_SIZE are ignored.
- V_SIZE, 768, active lines per frame; lines with y >= V_SIZE are ignored.
- EDGE_THRESH, 128, luma >= EDGE_THRESH marks an edge pixel.
- MIN_COUNT, 16, minimum edge pixels in a frame for the box to be valid.
- BOX_COLOR, 24'hFF0000, overlay colour.

Ports:
- video_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- hs  in  1  horizontal sync from the Sobel stage, passed through.
- vs  in  1  vertical sync, active high; frame start = rising edge.
- de  in  1  active video.
- vin_data  in  DATA_WIDTH  edge video (grey replicated).
- hs_o  out  1  hs delayed 1 cycle.
- vs_o  out  1  vs delayed 1 cycle.
- de_o  out  1  de delayed 1 cycle.
- vout_data  out  DATA_WIDTH  output video.
- edge_count  out  20  edge pixels in last completed frame.
- box_valid  out  1  last frame's box is valid.
- box_x0, box_x1  out  11  left/right box column.
- box_y0, box_y1  out  11  top/bottom box row.
- frame_done  out  1  one-cycle pulse when statistics update.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears everything:
  - all outputs, x/y counters, accumulators and shadow registers go to 0;
  - vs edge-detect register goes to 0;
  - box_valid=0, so no overlay is drawn until a full frame completes after reset.
- Frame start: vs_rise = vs & ~vs_q, with vs_q the 1-cycle registered vs.
- Position counters:
  - x increments on each de=1 cycle and clears when de=0.
  - y increments on each de falling edge (de_q & ~de) and clears on vs_rise.
  - Both are 11 bits and saturate at 2047.
- Edge pixel: de=1 and x<H_SIZE and y<V_SIZE and vin_data[7:0] >= EDGE_THRESH.
- Accumulators, per frame:
  - cnt saturates at 20'hFFFFF;
  - minx/miny initialised to 11'h7FF, maxx/maxy initialised to 0;
  - each edge pixel updates min/max and cnt.
- On vs_rise, in the same cycle:
  - shadow registers load cnt/minx/maxx/miny/maxy;
  - box_valid <= (cnt >= MIN_COUNT);
  - accumulators reinitialise;
  - frame_done=1 on the following cycle, coincident with the new shadow values.
- If vs_rise and an edge pixel coincide, that pixel is counted in the new frame: it is applied on top of the reinitialised accumulators.
- Overlay decision uses shadow values and the current x/y. Pixel is on the box when box_valid=1, de=1, and either:
  - (x==box_x0 or x==box_x1) and box_y0<=y<=box_y1; or
  - (y==box_y0 or y==box_y1) and box_x0<=x<=box_x1.
- Output pixel:
  - on the box: vout_data <= BOX_COLOR;
  - de=1 and not on the box: vout_data <= vin_data;
  - de=0: vout_data <= 0.
- Latency: exactly 1 cycle on vout_data, hs_o, vs_o, de_o.
- A frame without vs keeps accumulating; counters saturate, never wrap.

Optional Feature:
- Macro: EDGE_BINARIZE_EN.
- Defined: non-box active pixels output {DATA_WIDTH{1'b1}} if the pixel is an edge pixel, else 0. Latency is unchanged.
- Undefined: non-box active pixels pass vin_data unchanged.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with de toggling -> all outputs 0, box_valid=0, frame_done never pulses.
- Box capture (H_SIZE=16, V_SIZE=8, MIN_COUNT=2): frame with luma 0xFF at (3,2) and (10,5), all other pixels 0x00, then vs pulse -> frame_done pulses once; edge_count=2; box=(3,2)-(10,5); box_valid=1. Next frame with all-0x10 input -> at (3,4) and (7,2) vout_data=FF0000; at (4,4) vout_data=101010.
- Threshold boundary: frame with 5 pixels of 0x80 and 5 pixels of 0x7F -> edge_count=5.
- Below minimum: frame with 1 edge pixel, MIN_COUNT=2 -> box_valid=0, edge_count=1, no overlay in the next frame.
- Mid-frame reset: rst_n pulsed low during a box-drawing frame -> the cycle after reset release shows vout_data equal to the previous cycle's vin_data and box_valid=0. No overlay appears until a full vs-to-vs frame completes.
- Long line: 20 pixels of 0xFF per line with H_SIZE=16 -> x=16..19 excluded; box_x1=15; edge_count=16×lines.
